// File: rtl/lzc_share_arbiter.sv
// Round-robin share of one external 32-bit LZC; accept in N, tagged response valid in N+2, one result per 2 cycles.
// Backpressure: response held stable while rsp_ready_i=0; no request is accepted until the response drains.
module lzc_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*32-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [4:0]            rsp_index_o,
    output logic                  rsp_zero_o,
    output logic [31:0]           lzc_data_o,
    input  logic [4:0]            lzc_index_i,
    input  logic                  lzc_zero_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              accept;
    logic [31:0]       grant_data;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int k;
        logic [ID_W-1:0] idx;
        grant_id    = '0;
        grant_found = 1'b0;
        k           = 0;
        idx         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            idx = ID_W'(k);
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) grant_data = req_data_i[32*i +: 32];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EVAL;
            EVAL:    next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = accept ? EVAL : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Accept only while the response slot is free or being drained this cycle.
    always_comb begin
        accept      = !rst_i && grant_found &&
                      ((state == IDLE) || ((state == RESP) && rsp_ready_i));
        req_ready_o = accept ? (NUM_REQ'(1) << grant_id) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr         <= ID_W'(NUM_REQ - 1);
            cur_id      <= '0;
            lzc_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_index_o <= '0;
            rsp_zero_o  <= 1'b0;
        end else begin
            if (accept) begin
                lzc_data_o <= grant_data;
                cur_id     <= grant_id;
                ptr        <= grant_id;
            end
            if (state == EVAL) begin
                rsp_index_o <= lzc_zero_i ? 5'd0 : lzc_index_i;
                rsp_zero_o  <= lzc_zero_i;
                rsp_id_o    <= cur_id;
                rsp_valid_o <= 1'b1;
            end else if ((state == RESP) && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lzc_share_arbiter.sv
// Directed bench for lzc_share_arbiter with four requesters and a behavioural LZC on lzc_data_o.
module tb_lzc_share_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [4:0]   rsp_index;
    logic         rsp_zero;
    logic [31:0]  lzc_data;
    logic [4:0]   lzc_index;
    logic         lzc_zero;

    int checks = 0;
    int errors = 0;

    lzc_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_index_o (rsp_index),
        .rsp_zero_o  (rsp_zero),
        .lzc_data_o  (lzc_data),
        .lzc_index_i (lzc_index),
        .lzc_zero_i  (lzc_zero)
    );

    always #5 clk = ~clk;

    // Shared LZC; reports 31 on an all-zero operand so the zero override is visible.
    always_comb begin
        lzc_zero  = (lzc_data == 32'd0);
        lzc_index = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (lzc_data[i]) lzc_index = 5'(31 - i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic single(input int k, input logic [31:0] d, input logic [4:0] ei,
                          input logic ez, input string tag);
        req_valid[k] = 1'b1;
        req_data[32*k +: 32] = d;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << k));
        tick();
        req_valid[k] = 1'b0;
        chk({tag, "_lzc_data"}, lzc_data, d);
        chk({tag, "_eval_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_eval_vld"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(k));
        chk({tag, "_index"}, 32'(rsp_index), 32'(ei));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_drained"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with a valid request present to check ready is suppressed.
        #1 rst = 1'b1;
        req_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_index", 32'(rsp_index), 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        chk("rst_lzc_data", lzc_data, 32'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic counts and boundaries.
        single(0, 32'h0001_0000, 5'd15, 1'b0, "t1");
        single(0, 32'h8000_0000, 5'd0,  1'b0, "msb");
        single(0, 32'h0000_0000, 5'd0,  1'b1, "zero");
        single(0, 32'h0000_0001, 5'd31, 1'b0, "lsb");

        // Operand register only changes on accept.
        req_data[31:0] = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("lzc_hold", lzc_data, 32'h0000_0001);

        // Two requesters continuously valid alternate from requester 0.
        do_reset();
        req_data[31:0]  = 32'h00F0_0000;
        req_data[63:32] = 32'h0000_0F00;
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_ready", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_eval_ready", 32'(req_ready), 32'd0);
            tick();
            chk("rr_vld", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(g % 2));
            chk("rr_index", 32'(rsp_index), (g % 2 == 0) ? 32'd8 : 32'd20);
        end
        req_valid = 4'b0000;
        tick();
        rsp_ready = 1'b0;
        chk("rr_idle_vld", 32'(rsp_valid), 32'd0);

        // Response backpressure: stable outputs, no grants while stalled.
        req_data[31:0] = 32'h0000_8000;
        req_valid[0] = 1'b1;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_data[63:32] = 32'h0400_0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_index", 32'(rsp_index), 32'd16);
            chk("bp_zero", 32'(rsp_zero), 32'd0);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        rsp_ready = 1'b0;
        tick();
        chk("bp_next_id", 32'(rsp_id), 32'd1);
        chk("bp_next_index", 32'(rsp_index), 32'd5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Asynchronous reset during EVAL drops the transaction.
        req_data[63:32] = 32'h0000_0100;
        req_valid[1] = 1'b1;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        chk("ar_lzc_pre", lzc_data, 32'h0000_0100);
        rst = 1'b1;
        #1;
        chk("ar_lzc_data", lzc_data, 32'd0);
        chk("ar_vld", 32'(rsp_valid), 32'd0);
        chk("ar_id", 32'(rsp_id), 32'd0);
        chk("ar_index", 32'(rsp_index), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_no_stale1", 32'(rsp_valid), 32'd0);
        tick();
        chk("ar_no_stale2", 32'(rsp_valid), 32'd0);
        req_data[31:0] = 32'h0800_0000;
        req_valid = 4'b0011;
        #1;
        chk("ar_first_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("ar_rsp_id", 32'(rsp_id), 32'd0);
        chk("ar_rsp_index", 32'(rsp_index), 32'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Pointer at 1: requester 3 wins over requester 1.
        do_reset();
        single(1, 32'h0000_0010, 5'd27, 1'b0, "p1");
        req_data[63:32]  = 32'h2000_0000;
        req_data[127:96] = 32'h0004_0000;
        req_valid = 4'b1010;
        #1;
        chk("p_ready3", 32'(req_ready), 32'd8);
        tick();
        req_valid[3] = 1'b0;
        tick();
        chk("p_id3", 32'(rsp_id), 32'd3);
        chk("p_index3", 32'(rsp_index), 32'd13);
        rsp_ready = 1'b1;
        #1;
        chk("p_ready1", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        rsp_ready = 1'b0;
        tick();
        chk("p_id1", 32'(rsp_id), 32'd1);
        chk("p_index1", 32'(rsp_index), 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
